// File: rtl/beam_trigger_holdoff.sv
// Beam trigger holdoff: masks beams, captures timestamped events, applies holdoff.
// Optional per-beam rate scalers are enabled by defining L1_TRIG_SCALERS_EN.
module beam_trigger_holdoff #(
  parameter int NBEAMS    = 46,
  parameter int TIME_W    = 32,
  parameter int HOLDOFF_W = 16,
  parameter int SCALER_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NBEAMS-1:0]            trigger_i,
  input  logic [NBEAMS-1:0]            mask_i,
  input  logic                         enable_i,
  input  logic [HOLDOFF_W-1:0]         holdoff_i,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [NBEAMS-1:0]            evt_beams_o,
  output logic [TIME_W-1:0]            evt_time_o,
  output logic [15:0]                  dropped_o,
  input  logic [31:0]                  scaler_period_i,
  output logic [NBEAMS*SCALER_W-1:0]   scaler_o,
  output logic                         scaler_valid_o
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;

  state_e                state_q, state_d;
  logic [NBEAMS-1:0]     trig_q, mask_q;
  logic                  enable_q;
  logic [TIME_W-1:0]     tcnt_q, time_q;
  logic [NBEAMS-1:0]     beams_q, beams_d;
  logic [TIME_W-1:0]     etime_q, etime_d;
  logic [HOLDOFF_W-1:0]  hold_q, hold_d, hold_dec;
  logic                  valid_q, valid_d;
  logic [15:0]           drop_q, drop_d;
  logic [NBEAMS-1:0]     qual;
  logic                  hit, hs;

  assign qual = trig_q & ~mask_q;
  assign hit  = (|qual) & enable_q;
  assign hs   = valid_q & evt_ready_i;

  always_comb begin
    state_d  = state_q;
    beams_d  = beams_q;
    etime_d  = etime_q;
    hold_d   = hold_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
    hold_dec = (hold_q == '0) ? '0 : hold_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          beams_d = qual;
          etime_d = time_q;
          valid_d = 1'b1;
          hold_d  = holdoff_i;
          state_d = PEND;
        end
      end
      PEND: begin
        hold_d = hold_dec;
        if (hs) begin
          if (hold_q == '0 && hit) begin
            beams_d = qual;
            etime_d = time_q;
            hold_d  = holdoff_i;
          end else if (hold_dec == '0) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            valid_d = 1'b0;
            state_d = HOLD;
          end
        end else if (hold_q == '0 && hit && drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
      HOLD: begin
        hold_d = hold_dec;
        // the cycle after the count runs out is already IDLE, so capture can resume
        if (hold_dec == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      trig_q   <= '0;
      mask_q   <= '0;
      enable_q <= 1'b0;
      tcnt_q   <= '0;
      time_q   <= '0;
      beams_q  <= '0;
      etime_q  <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trigger_i;
      mask_q   <= mask_i;
      enable_q <= enable_i;
      tcnt_q   <= tcnt_q + 1'b1;
      time_q   <= tcnt_q;
      beams_q  <= beams_d;
      etime_q  <= etime_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_beams_o = beams_q;
  assign evt_time_o  = etime_q;
  assign dropped_o   = drop_q;

`ifdef L1_TRIG_SCALERS_EN
  logic [31:0]                per_q, per_d, pact_q, cur_per;
  logic [NBEAMS*SCALER_W-1:0] cnt_q, cnt_d, inc, sc_q, sc_d;
  logic                       sv_q, sv_d, term;

  always_comb begin
    // a new period value is only picked up at the start of a gate
    cur_per = (per_q == 32'd0) ? scaler_period_i : pact_q;
    term    = (cur_per != 32'd0) && (per_q + 32'd1 == cur_per);
    for (int b = 0; b < NBEAMS; b++) begin
      if (&cnt_q[b*SCALER_W +: SCALER_W])
        inc[b*SCALER_W +: SCALER_W] = cnt_q[b*SCALER_W +: SCALER_W];
      else
        inc[b*SCALER_W +: SCALER_W] = cnt_q[b*SCALER_W +: SCALER_W]
                                      + SCALER_W'(trig_q[b]);
    end
    sc_d  = sc_q;
    sv_d  = 1'b0;
    per_d = per_q + 32'd1;
    cnt_d = inc;
    if (cur_per == 32'd0) begin
      per_d = '0;
      cnt_d = '0;
    end else if (term) begin
      sc_d  = inc;
      sv_d  = 1'b1;
      per_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q  <= '0;
      pact_q <= '0;
      cnt_q  <= '0;
      sc_q   <= '0;
      sv_q   <= 1'b0;
    end else begin
      per_q  <= per_d;
      pact_q <= cur_per;
      cnt_q  <= cnt_d;
      sc_q   <= sc_d;
      sv_q   <= sv_d;
    end
  end

  assign scaler_o       = sc_q;
  assign scaler_valid_o = sv_q;
`else
  logic unused_period;
  assign unused_period  = ^scaler_period_i;
  assign scaler_o       = '0;
  assign scaler_valid_o = 1'b0;
`endif

endmodule
